mine_placer: RTL
================

Name: mine_placer

Overview:
Sequencer that populates the minefield at game start by consuming the 8-bit pseudo-random stream from the board's LFSR generator. Each cycle it samples one random cell index and accepts or rejects it. A drawn index is rejected if it is out of range, equals the player's first-click (safe) cell, or is already mined. Accepted mines go into an internal occupancy bitmap and are also emitted as write strobes to the board RAM. Sits between the game FSM (start/done) and the random generator / board storage.

Parameters:
ROWS, 16, grid rows
COLS, 16, grid columns; ROWS*COLS must be <= 256
NUM_MINES, 40, mines to place; must be 1..ROWS*COLS-1
MAX_TRIES, 512, draw cycles allowed before abort with error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin placement; ignored while busy
safe_cell  input  8  linear index (row*COLS+col) that must stay mine-free; sampled on accepted start
rnd  input  8  random value from generator, free-running, new value each cycle
busy  output  1  high from the cycle after accepted start until DONE
done  output  1  one-cycle pulse when placement ends (success or abort)
err  output  1  sticky abort flag; cleared on next accepted start
mine_cnt  output  8  mines placed so far
wr_en  output  1  one-cycle strobe per accepted mine
wr_addr  output  8  cell index written; valid when wr_en
qry_addr  input  8  bitmap read address
qry_mine  output  1  registered bitmap bit for qry_addr, 1-cycle latency; 0 if qry_addr >= ROWS*COLS

Behaviour:
- Reset (async, reset==0): state IDLE, bitmap all 0, busy=0, done=0, err=0, mine_cnt=0, wr_en=0, wr_addr=0, qry_mine=0, safe register=0, try counter=0. Applies immediately mid-placement, and the bitmap is lost.
- States: IDLE, CLEAR, DRAW, FIN.
- IDLE: on start=1, latch safe_cell, clear err, go to CLEAR.
- CLEAR, 1 cycle: bitmap<=0, mine_cnt<=0, tries<=0, then go to DRAW. busy=1 from this cycle.
- DRAW: each cycle evaluate rnd combinationally.
  - Accept iff rnd < ROWS*COLS, rnd != safe, and bitmap[rnd]==0.
  - On accept, in the same edge: bitmap[rnd]<=1, mine_cnt++, wr_en<=1, wr_addr<=rnd. The strobe is visible the next cycle.
  - tries++ every DRAW cycle.
  - If an accept brings mine_cnt to NUM_MINES, go to FIN.
  - Else if tries==MAX_TRIES-1 with no finishing accept, set err<=1 and go to FIN.
  - A finishing accept takes priority over timeout in the same cycle.
- FIN, 1 cycle: done=1, busy=0, then go to IDLE. start is ignored in FIN.
- start while busy: ignored, with no restart.
- The bitmap persists in IDLE after completion so the game can query it. qry_mine is always active, including during DRAW, where it reads the current bitmap.
- wr_en is never asserted in IDLE, CLEAR or FIN, except for the trailing strobe from the final accept, which appears during the FIN cycle.
- A full-period 8-bit generator visits every value within 256 cycles, so the default configuration completes well below MAX_TRIES. err signals only misconfiguration or a stalled source.
- Width rules: internal cell count = ROWS*COLS, computed as a 9-bit constant. tries counter width = clog2(MAX_TRIES)+1.

Decomposition:
- Shared game package holds:
  - CELLS = ROWS*COLS constant
  - Cell-index typedef, 8 bits
  - State enum {IDLE, CLEAR, DRAW, FIN}
  - Linear-index helper, row*COLS+col, also used by the board/reveal logic
- One natural sub-module: mine_bitmap, a 256-bit register array with:
  - synchronous clear
  - single-bit set port
  - combinational read, used for the accept test
  - registered read, used for the query port
- Placer FSM and counters stay in the top module.

Test Plan:
- Reset mid-DRAW: assert reset after 10 mines placed -> immediately busy=0, mine_cnt=0, qry_mine=0 for previously set cells, no done pulse.
- Scripted rnd 5,5,7,200,9 with ROWS=COLS=8 (CELLS=64), safe=7, NUM_MINES=2 -> accepts 5 and 9 only; wr_en at addresses 5 then 9; done pulse 1 cycle after the 9 accept; mine_cnt=2, err=0.
- Drive rnd with the real LFSR, default params, safe=0 -> done within 256 DRAW cycles, mine_cnt=40. Sweep qry_addr 0..255: exactly 40 ones, qry_mine(0)=0, and the ones match the set of wr_addr values logged.
- rnd held constant at 3, NUM_MINES=2, MAX_TRIES=16 -> one accept (3), then err=1 and done after 16 DRAW cycles; mine_cnt=1.
- start pulsed again while busy -> ignored and placement completes unchanged. New start after done -> CLEAR zeroes the bitmap, err cleared, fresh placement.
- Final accept on the same cycle tries hits MAX_TRIES-1 -> err=0, done=1, mine_cnt=NUM_MINES.

Source files
------------

// File: rtl/mine_placer_pkg.sv
// Shared game definitions: cell indexing, placer state encoding, board size helpers.
package mine_placer_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 16;
    localparam int CELLS    = ROWS_DEF * COLS_DEF;

    typedef logic [7:0] cell_t;

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FIN} state_t;

    // Cell count as a 9-bit value so a full 256-cell board still compares cleanly.
    function automatic logic [8:0] cells_of(input int rows, input int cols);
        return 9'(rows * cols);
    endfunction

    function automatic cell_t lin_idx(input int unsigned row, input int unsigned col,
                                      input int unsigned cols);
        return cell_t'(row * cols + col);
    endfunction

endpackage

// File: rtl/mine_placer_if.sv
// Handshake, random source, board-write and query signals of the mine placer.
interface mine_placer_if;
    import mine_placer_pkg::*;

    logic  start;
    cell_t safe_cell;
    cell_t rnd;
    logic  busy;
    logic  done;
    logic  err;
    cell_t mine_cnt;
    logic  wr_en;
    cell_t wr_addr;
    cell_t qry_addr;
    logic  qry_mine;

    modport slave (
        input  start, safe_cell, rnd, qry_addr,
        output busy, done, err, mine_cnt, wr_en, wr_addr, qry_mine
    );

    modport master (
        output start, safe_cell, rnd, qry_addr,
        input  busy, done, err, mine_cnt, wr_en, wr_addr, qry_mine
    );

endinterface

// File: rtl/mine_bitmap.sv
// 256-entry mine occupancy map: sync clear, single-bit set, comb read for the
// accept test and a registered read for the game's query port.
module mine_bitmap
    import mine_placer_pkg::*;
#(
    parameter logic [8:0] NCELLS = 9'd256
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clr_i,
    input  logic  set_i,
    input  cell_t set_addr_i,
    input  cell_t rd_addr_i,
    output logic  rd_bit_o,
    input  cell_t qry_addr_i,
    output logic  qry_bit_o
);

    logic [255:0] bits_q, bits_d;
    logic         qry_q, qry_d;

    always_comb begin
        bits_d = bits_q;
        if (clr_i)
            bits_d = '0;
        else if (set_i)
            bits_d[set_addr_i] = 1'b1;
    end

    // Query sees the map as it stood before this edge's set/clear.
    always_comb begin
        qry_d = 1'b0;
        if ({1'b0, qry_addr_i} < NCELLS)
            qry_d = bits_q[qry_addr_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bits_q <= '0;
            qry_q  <= 1'b0;
        end else begin
            bits_q <= bits_d;
            qry_q  <= qry_d;
        end
    end

    assign rd_bit_o  = bits_q[rd_addr_i];
    assign qry_bit_o = qry_q;

endmodule

// File: rtl/mine_placer.sv
// Mine placement sequencer: draws one random cell per cycle, rejects out-of-range,
// safe or already-mined cells, and streams accepted mines to the board RAM.
module mine_placer
    import mine_placer_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int NUM_MINES = 40,
    parameter int MAX_TRIES = 512
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mine_placer_if.slave  bus
);

    localparam logic [8:0] NCELLS = cells_of(ROWS, COLS);
    localparam int         TW     = $clog2(MAX_TRIES) + 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
    localparam cell_t      NM     = cell_t'(NUM_MINES);

    state_t        state_q, state_d;
    cell_t         safe_q, safe_d;
    logic          err_q, err_d;
    cell_t         cnt_q, cnt_d;
    logic [TW-1:0] tries_q, tries_d;
    logic          wr_en_q, wr_en_d;
    cell_t         wr_addr_q, wr_addr_d;

    logic busy, done, draw, bm_clr, bm_rd, qry_bit;
    logic accept, finish, timeout;

    mine_bitmap #(.NCELLS(NCELLS)) u_bitmap (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (bm_clr),
        .set_i      (accept),
        .set_addr_i (bus.rnd),
        .rd_addr_i  (bus.rnd),
        .rd_bit_o   (bm_rd),
        .qry_addr_i (bus.qry_addr),
        .qry_bit_o  (qry_bit)
    );

    assign accept  = draw && ({1'b0, bus.rnd} < NCELLS) && (bus.rnd != safe_q) && !bm_rd;
    assign finish  = accept && ((cnt_q + 8'd1) == NM);
    assign timeout = draw && (tries_q == LAST_TRY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A finishing accept wins over timeout on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR:   state_d = DRAW;
            DRAW:    if (finish || timeout) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == CLEAR) || (state_q == DRAW);
        done   = (state_q == FIN);
        draw   = (state_q == DRAW);
        bm_clr = (state_q == CLEAR);
    end

    always_comb begin
        safe_d    = safe_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        wr_en_d   = accept;
        wr_addr_d = wr_addr_q;
        if (state_q == IDLE && bus.start) begin
            safe_d = bus.safe_cell;
            err_d  = 1'b0;
        end
        if (bm_clr) begin
            cnt_d   = '0;
            tries_d = '0;
        end
        if (draw) begin
            tries_d = tries_q + TW'(1);
            if (timeout && !finish) err_d = 1'b1;
        end
        if (accept) begin
            cnt_d     = cnt_q + 8'd1;
            wr_addr_d = bus.rnd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            safe_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            tries_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            safe_q    <= safe_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            tries_q   <= tries_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err_q;
    assign bus.mine_cnt = cnt_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.qry_mine = qry_bit;

endmodule
